op_dispatcher: RTL
==================

// Module: op_dispatcher
// PURPOSE
//  Host-side command issuer for the LWE operation controller. Queues host commands (opcode + three base
//  addresses + noise), pulses config_en one command at a time, tracks start (en) and completion (done),
//  and returns a tagged completion record per command. Flags a timeout error if done never arrives.
// PARAMETERS
//  ADDR_WIDTH     10   width of op1/op2/out base addresses
//  BIG_N          30   width of noise vector
//  CMD_DEPTH      4    command queue entries (power of two)
//  CMD_PTR_WIDTH  2    log2(CMD_DEPTH)
//  TAG_WIDTH      4    completion tag width; tags wrap modulo 2^TAG_WIDTH
//  TIMEOUT        255  max cycles in WAIT_START+BUSY before error
//  TIMEOUT_WIDTH  8    timeout counter width; must hold TIMEOUT
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              reset: synchronous, active-low
//  cmd_valid      in   1              host command valid
//  cmd_ready      out  1              queue can accept; = rst_n && (count < CMD_DEPTH)
//  cmd_opcode     in   2              ENCRYPT/DECRYPT/ADD/MULT
//  cmd_op1_base   in   ADDR_WIDTH     operand 1 base address
//  cmd_op2_base   in   ADDR_WIDTH     operand 2 base address
//  cmd_out_base   in   ADDR_WIDTH     result base address
//  cmd_noise      in   BIG_N          noise vector
//  next_tag       out  TAG_WIDTH      tag assigned to the next accepted command
//  config_en      out  1              one-cycle configure pulse to controller
//  opcode         out  2              registered opcode to controller
//  op1_base_addr  out  ADDR_WIDTH     registered to controller
//  op2_base_addr  out  ADDR_WIDTH     registered to controller
//  out_base_addr  out  ADDR_WIDTH     registered to controller
//  noise          out  BIG_N          registered to controller
//  ctrl_en        in   1              controller en
//  ctrl_done      in   1              controller done (level; held until next configure)
//  cmp_valid      out  1              one-cycle completion pulse
//  cmp_tag        out  TAG_WIDTH      tag of completed command
//  cmp_error      out  1              completion was a timeout, valid with cmp_valid
//  busy           out  1              FSM not IDLE or queue non-empty
// BEHAVIOUR
//  Reset: every output 0 (cmd_ready 0 while rst_n low), queue empty, next_tag 0, FSM IDLE.
//  Enqueue on edge with cmd_valid&&cmd_ready; entry stores fields + next_tag; next_tag++ (wraps).
//  No push bypass: full queue holds cmd_ready low even if popping that cycle.
//  FSM IDLE -> CONFIG: queue non-empty; pop at this edge, load opcode/addr/noise/tag registers.
//  CONFIG: config_en=1 for exactly this cycle -> WAIT_START; clear timeout counter.
//  WAIT_START: ignore ctrl_done (stale done is cleared by configure); ctrl_en=1 -> BUSY.
//  BUSY: ctrl_done=1 -> COMPLETE (error=0).
//  WAIT_START/BUSY: counter++ per cycle; reaching TIMEOUT -> COMPLETE with error=1.
//   If ctrl_done and timeout occur in the same cycle, done wins (error=0).
//  COMPLETE: cmp_valid=1, cmp_tag, cmp_error for one cycle -> IDLE.
//  Latency: accept at edge E0 -> pop at E1 -> config_en high E1..E2 -> controller latches at E2.
//  Back-to-back: minimum 1 IDLE cycle between COMPLETE and the next CONFIG.
//  Outputs opcode/addr/noise are stable from pop until the next pop.
//  Reset mid-operation: queue flushed, in-flight command dropped with no completion, config_en low.
//  Push during COMPLETE/CONFIG allowed; ordering strictly FIFO.
// STRUCTURE
//  Shared header: OPCODE_ENCRYPT/DECRYPT/ADD/MULT macros (same as controller), FSM state encodings.
//  Sub-module cmd_fifo: sync FIFO, CMD_DEPTH x (2+3*ADDR_WIDTH+BIG_N+TAG_WIDTH),
//  push/pop/count/full/empty, registered storage, wrap-around pointers.
//  Top: FSM, timeout counter, tag counter, output registers.
// TESTING
//  1 Reset, single ADD (op1=0,op2=16,out=32) -> config_en 1 cycle, fields match; done -> cmp_valid, tag=0, err=0.
//  2 Push 5 cmds back-to-back with ctrl stalled -> cmd_ready low after 4; issued in order, tags 0..4.
//  3 Hold ctrl_done=1 from prior op across CONFIG -> no early completion; complete only after en then done.
//  4 Never raise ctrl_done, TIMEOUT=20 -> cmp_valid with cmp_error=1 after 20 cycles; next cmd issues.
//  5 ctrl_done on the exact timeout cycle -> cmp_error=0.
//  6 rst_n low while BUSY with 2 queued -> no cmp_valid, queue empty, next_tag 0, config_en 0.

Source files
------------

// File: rtl/op_dispatcher_pkg.sv
// rtl/op_dispatcher_pkg.sv - shared opcode encodings and FSM states for op_dispatcher
package op_dispatcher_pkg;

    localparam int OPCODE_WIDTH = 2;

    // Must match the operation controller's decode
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_ENCRYPT = 2'd0;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_DECRYPT = 2'd1;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_ADD     = 2'd2;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_MULT    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_WAIT_START,
        ST_BUSY,
        ST_COMPLETE
    } state_t;

endpackage

// File: rtl/op_dispatcher_cmd_fifo.sv
// rtl/op_dispatcher_cmd_fifo.sv - synchronous command FIFO with wrap-around pointers
module op_dispatcher_cmd_fifo #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic [PTR_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count == (PTR_WIDTH+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_WIDTH+1)'(do_push) - (PTR_WIDTH+1)'(do_pop);
        end
    end

    // Storage needs no reset; the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/op_dispatcher.sv
// rtl/op_dispatcher.sv - queues host commands and issues them one at a time to the LWE controller
module op_dispatcher
    import op_dispatcher_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int BIG_N         = 30,
    parameter int CMD_DEPTH     = 4,
    parameter int CMD_PTR_WIDTH = 2,
    parameter int TAG_WIDTH     = 4,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_op1_base,
    input  logic [ADDR_WIDTH-1:0] cmd_op2_base,
    input  logic [ADDR_WIDTH-1:0] cmd_out_base,
    input  logic [BIG_N-1:0]      cmd_noise,
    output logic [TAG_WIDTH-1:0]  next_tag,
    output logic                  config_en,
    output logic [1:0]            opcode,
    output logic [ADDR_WIDTH-1:0] op1_base_addr,
    output logic [ADDR_WIDTH-1:0] op2_base_addr,
    output logic [ADDR_WIDTH-1:0] out_base_addr,
    output logic [BIG_N-1:0]      noise,
    input  logic                  ctrl_en,
    input  logic                  ctrl_done,
    output logic                  cmp_valid,
    output logic [TAG_WIDTH-1:0]  cmp_tag,
    output logic                  cmp_error,
    output logic                  busy
);

    localparam int ENTRY_WIDTH = 2 + 3*ADDR_WIDTH + BIG_N + TAG_WIDTH;

    state_t                   state;
    state_t                   state_d;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CMD_PTR_WIDTH:0]   fifo_count;
    logic [ENTRY_WIDTH-1:0]   push_entry;
    logic [ENTRY_WIDTH-1:0]   pop_entry;
    logic [TAG_WIDTH-1:0]     next_tag_q;
    logic [TAG_WIDTH-1:0]     cur_tag_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     timed_out;
    logic                     finish;
    logic                     finish_err;
    logic                     err_q;

    // No push bypass: a full queue refuses even when the FSM pops this cycle
    assign cmd_ready  = rst_n && !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign push_entry = {cmd_opcode, cmd_op1_base, cmd_op2_base, cmd_out_base, cmd_noise, next_tag_q};

    op_dispatcher_cmd_fifo #(
        .DEPTH     (CMD_DEPTH),
        .PTR_WIDTH (CMD_PTR_WIDTH),
        .WIDTH     (ENTRY_WIDTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (pop_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign timed_out = (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1));

    always_comb begin
        state_d    = state;
        fifo_pop   = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_CONFIG;
                end
            end
            ST_CONFIG: state_d = ST_WAIT_START;
            // A done left high by the previous op is stale here and ignored
            ST_WAIT_START: begin
                if (timed_out) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                    state_d    = ST_COMPLETE;
                end else if (ctrl_en) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ctrl_done || timed_out) begin
                    finish     = 1'b1;
                    finish_err = !ctrl_done;
                    state_d    = ST_COMPLETE;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            next_tag_q    <= '0;
            cur_tag_q     <= '0;
            err_q         <= 1'b0;
            tmo_cnt       <= '0;
            opcode        <= '0;
            op1_base_addr <= '0;
            op2_base_addr <= '0;
            out_base_addr <= '0;
            noise         <= '0;
        end else begin
            state <= state_d;
            if (fifo_push) next_tag_q <= next_tag_q + 1'b1;
            if (fifo_pop) begin
                {opcode, op1_base_addr, op2_base_addr, out_base_addr, noise, cur_tag_q} <= pop_entry;
            end
            if (finish) err_q <= finish_err;
            if (state == ST_CONFIG) begin
                tmo_cnt <= '0;
            end else if (state == ST_WAIT_START || state == ST_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign next_tag  = next_tag_q;
    assign config_en = (state == ST_CONFIG);
    assign cmp_valid = (state == ST_COMPLETE);
    assign cmp_tag   = cur_tag_q;
    assign cmp_error = cmp_valid && err_q;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

endmodule
